flp_imult_seq: RTL and testbench



---
 rtl/flp_imult_seq_pkg.sv | 21 ++
 rtl/flp_imult_seq_step.sv | 23 ++
 rtl/flp_imult_seq.sv | 138 +++++++++++++
 tb/tb_flp_imult_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_imult_seq_pkg.sv
// Shared definitions for the sequential integer multiplier: FSM encoding and
// counter sizing helper.
package flp_imult_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Width of the step counter, which holds N-1 down to 0 where N = width/radix_bits.
   function automatic int cnt_width(input int width, input int radix_bits);
      int n;
      n = width / radix_bits;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/flp_imult_seq_step.sv
// Combinational partial-product generator: multiplicand times one RADIX_BITS
// digit of the multiplier, built as a small shift-and-add.
module flp_imult_seq_step #(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 2
) (
   input  logic [WIDTH-1:0]            mlpd_i,
   input  logic [RADIX_BITS-1:0]       digit_i,
   output logic [WIDTH+RADIX_BITS-1:0] pp_o
);

   localparam int PPW = WIDTH + RADIX_BITS;

   always_comb begin
      pp_o = '0;
      for (int i = 0; i < RADIX_BITS; i++) begin
         if (digit_i[i]) begin
            pp_o = pp_o + (PPW'(mlpd_i) << i);
         end
      end
   end

endmodule

// File: rtl/flp_imult_seq.sv
// Iterative multiplier retiring RADIX_BITS multiplier bits per cycle, with
// sign handled by magnitude multiply plus a final conditional negate.
//
// state  | meaning
// IDLE   | o_ready high, waiting for operands
// RUN    | one partial product accumulated per cycle, N cycles
// FIX    | apply sign to accumulator, load product register
// DONE   | o_valid high, product held until i_ready
module flp_imult_seq
   import flp_imult_seq_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 2
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_mlpr,
   input  logic [WIDTH-1:0]     i_mlpd,
   input  logic                 i_signed,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [2*WIDTH-1:0]   o_prod
);

   localparam int N   = WIDTH / RADIX_BITS;
   localparam int CW  = cnt_width(WIDTH, RADIX_BITS);
   localparam int PW  = 2 * WIDTH;
   localparam int PPW = WIDTH + RADIX_BITS;

   if ((WIDTH % RADIX_BITS) != 0) begin : g_chk_div
      $error("flp_imult_seq: WIDTH (%0d) is not a multiple of RADIX_BITS (%0d)", WIDTH, RADIX_BITS);
   end
   if ((RADIX_BITS != 1) && (RADIX_BITS != 2) && (RADIX_BITS != 4) && (RADIX_BITS != 8)) begin : g_chk_radix
      $error("flp_imult_seq: RADIX_BITS (%0d) must be 1, 2, 4 or 8", RADIX_BITS);
   end

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  mlpr_q, mlpr_d;
   logic [WIDTH-1:0]  mlpd_q, mlpd_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     prod_q, prod_d;

   logic [PPW-1:0]            pp;
   logic [PPW-1:0]            hi_sum;
   logic [PW+RADIX_BITS-1:0]  acc_wide;
   logic [PW-1:0]             acc_step;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   flp_imult_seq_step #(
      .WIDTH      (WIDTH),
      .RADIX_BITS (RADIX_BITS)
   ) u_step (
      .mlpd_i  (mlpd_q),
      .digit_i (mlpr_q[RADIX_BITS-1:0]),
      .pp_o    (pp)
   );

   // Accumulator shifts right each step; the new digit's product always lands
   // at bit WIDTH, and after N steps the full product is right-aligned.
   always_comb begin
      hi_sum   = PPW'(acc_q[PW-1:WIDTH]) + pp;
      acc_wide = {hi_sum, acc_q[WIDTH-1:0]};
      acc_step = PW'(acc_wide >> RADIX_BITS);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mlpr_d  = mlpr_q;
      mlpd_d  = mlpd_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               state_d = S_RUN;
               mlpr_d  = magnitude(i_mlpr, i_signed);
               mlpd_d  = magnitude(i_mlpd, i_signed);
               neg_d   = i_signed & (i_mlpr[WIDTH-1] ^ i_mlpd[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = CW'(N - 1);
            end
         end
         S_RUN: begin
            acc_d  = acc_step;
            mlpr_d = mlpr_q >> RADIX_BITS;
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIX: begin
            prod_d  = neg_q ? -acc_q : acc_q;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (i_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mlpr_q  <= '0;
         mlpd_q  <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mlpr_q  <= mlpr_d;
         mlpd_q  <= mlpd_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_prod  = prod_q;

endmodule

// File: tb/tb_flp_imult_seq.sv
// Bench for flp_imult_seq: one 32-bit radix-2 instance plus 16-bit instances at
// radix 1, 4 and 8, all checked every cycle against a transaction-level model.
module tb_flp_imult_seq;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]        v_in, sgn, rdy_in, ordy, ovld;
   logic [3:0][31:0]  mlpr, mlpd;
   logic [63:0]       prod0;
   logic [3:1][31:0]  prod_s;

   int n_vec = 0;
   int n_err = 0;

   flp_imult_seq #(.WIDTH(32), .RADIX_BITS(2)) u_dut (
      .clk(clk), .nrst(nrst), .i_valid(v_in[0]), .o_ready(ordy[0]),
      .i_mlpr(mlpr[0]), .i_mlpd(mlpd[0]), .i_signed(sgn[0]),
      .o_valid(ovld[0]), .i_ready(rdy_in[0]), .o_prod(prod0)
   );

   for (genvar g = 1; g < 4; g++) begin : g_sweep
      localparam int RB = (g == 1) ? 1 : (g == 2) ? 4 : 8;
      flp_imult_seq #(.WIDTH(16), .RADIX_BITS(RB)) u_dut (
         .clk(clk), .nrst(nrst), .i_valid(v_in[g]), .o_ready(ordy[g]),
         .i_mlpr(mlpr[g][15:0]), .i_mlpd(mlpd[g][15:0]), .i_signed(sgn[g]),
         .o_valid(ovld[g]), .i_ready(rdy_in[g]), .o_prod(prod_s[g])
      );
   end

   function automatic int wid_of(input int k);
      return (k == 0) ? 32 : 16;
   endfunction

   // Cycles from the operand-presenting cycle to the first o_valid cycle: WIDTH/RADIX_BITS + 2.
   function automatic int lat_of(input int k);
      case (k)
         0:       return 18;
         1:       return 18;
         2:       return 6;
         default: return 4;
      endcase
   endfunction

   function automatic logic [63:0] dut_prod(input int k);
      case (k)
         0:       return prod0;
         1:       return {32'b0, prod_s[1]};
         2:       return {32'b0, prod_s[2]};
         default: return {32'b0, prod_s[3]};
      endcase
   endfunction

   function automatic logic [63:0] ref_prod(input int k, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
      longint      sa, sb;
      logic [63:0] p;
      if (wid_of(k) == 32) begin
         sa = s ? longint'($signed(a)) : longint'({32'b0, a});
         sb = s ? longint'($signed(b)) : longint'({32'b0, b});
      end else begin
         sa = s ? longint'($signed(a[15:0])) : longint'({48'b0, a[15:0]});
         sb = s ? longint'($signed(b[15:0])) : longint'({48'b0, b[15:0]});
      end
      p = 64'(sa * sb);
      if (wid_of(k) == 16) p[63:32] = '0;
      return p;
   endfunction

   // Transaction model: busy for a fixed latency after accept, then holds the product until taken.
   logic        m_ready [4];
   logic        m_valid [4];
   logic [63:0] m_prod  [4];
   logic [63:0] m_exp   [4];
   int          m_wait  [4];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int k = 0; k < 4; k++) begin
            m_ready[k] <= 1'b1;
            m_valid[k] <= 1'b0;
            m_prod[k]  <= '0;
            m_exp[k]   <= '0;
            m_wait[k]  <= 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (m_ready[k] && v_in[k]) begin
               m_ready[k] <= 1'b0;
               m_wait[k]  <= lat_of(k) - 1;
               m_exp[k]   <= ref_prod(k, mlpr[k], mlpd[k], sgn[k]);
            end else if (m_wait[k] > 0) begin
               m_wait[k] <= m_wait[k] - 1;
               if (m_wait[k] == 1) begin
                  m_valid[k] <= 1'b1;
                  m_prod[k]  <= m_exp[k];
               end
            end else if (m_valid[k] && rdy_in[k]) begin
               m_valid[k] <= 1'b0;
               m_ready[k] <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (ovld[k] !== m_valid[k]) begin
            n_err++;
            $display("FAIL o_valid dut%0d @%0t: got %b expected %b", k, $time, ovld[k], m_valid[k]);
         end
         n_vec++;
         if (ordy[k] !== m_ready[k]) begin
            n_err++;
            $display("FAIL o_ready dut%0d @%0t: got %b expected %b", k, $time, ordy[k], m_ready[k]);
         end
         n_vec++;
         if (dut_prod(k) !== m_prod[k]) begin
            n_err++;
            $display("FAIL o_prod dut%0d @%0t: got %h expected %h", k, $time, dut_prod(k), m_prod[k]);
         end
      end
   end

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   // Called just after a negedge. Returns product seen on first o_valid and the latency.
   task automatic txn(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int hold, output logic [63:0] p, output int lat);
      int t;
      p   = '0;
      lat = -1;
      for (t = 0; t < 50 && !ordy[k]; t++) @(negedge clk);
      if (!ordy[k]) check_eq("ready_timeout", 64'(ordy[k]), 64'd1);
      mlpr[k] = a;
      mlpd[k] = b;
      sgn[k]  = s;
      v_in[k] = 1'b1;
      @(negedge clk);
      t = 1;
      while (!ovld[k] && t < 100) begin
         v_in[k]   = 1'($urandom_range(0, 1));
         rdy_in[k] = 1'($urandom_range(0, 1));
         mlpr[k]   = $urandom;
         mlpd[k]   = $urandom;
         sgn[k]    = 1'($urandom_range(0, 1));
         @(negedge clk);
         t++;
      end
      rdy_in[k] = 1'b0;
      if (!ovld[k]) begin
         check_eq("valid_timeout", 64'(ovld[k]), 64'd1);
      end else begin
         lat = t;
         p   = dut_prod(k);
         repeat (hold) begin
            v_in[k] = 1'($urandom_range(0, 1));
            mlpr[k] = $urandom;
            @(negedge clk);
         end
         if (hold > 0) check_eq("hold_prod", dut_prod(k), p);
      end
      v_in[k]   = 1'b0;
      rdy_in[k] = 1'b1;
      @(negedge clk);
      rdy_in[k] = 1'b0;
   endtask

   logic [63:0] p;
   int          lat;

   initial begin
      logic [31:0] a, b;
      logic        s;
      v_in = '0; sgn = '0; rdy_in = '0; mlpr = '0; mlpd = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 64'(ordy[0]), 64'd1);
      check_eq("rst_valid", 64'(ovld[0]), 64'd0);
      check_eq("rst_prod", prod0, 64'd0);
      nrst = 1'b1;
      @(negedge clk);

      txn(0, 32'h0000_0003, 32'h0000_0005, 1'b0, 0, p, lat);
      check_eq("u_3x5", p, 64'h0000_0000_0000_000F);
      check_eq("u_3x5_lat", 64'(lat), 64'd18);
      txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, p, lat);
      check_eq("u_max", p, 64'hFFFF_FFFE_0000_0001);
      txn(0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0, p, lat);
      check_eq("s_m3x7", p, 64'hFFFF_FFFF_FFFF_FFEB);
      txn(0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 0, p, lat);
      check_eq("u_fffffffdx7", p, 64'h0000_0006_FFFF_FFEB);
      txn(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 10, p, lat);
      check_eq("s_min_sq", p, 64'h4000_0000_0000_0000);
      check_eq("accept_next", 64'(ordy[0]), 64'd1);
      txn(0, 32'h0000_1234, 32'h0000_0010, 1'b0, 0, p, lat);
      check_eq("after_bp", p, 64'h0000_0000_0001_2340);
      check_eq("after_bp_lat", 64'(lat), 64'd18);

      mlpr[0] = 32'd7; mlpd[0] = 32'd11; sgn[0] = 1'b0; v_in[0] = 1'b1;
      @(negedge clk);
      v_in[0] = 1'b0;
      repeat (4) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      check_eq("mid_rst_valid", 64'(ovld[0]), 64'd0);
      check_eq("mid_rst_prod", prod0, 64'd0);
      check_eq("mid_rst_ready", 64'(ordy[0]), 64'd1);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      txn(0, 32'd2, 32'd9, 1'b0, 0, p, lat);
      check_eq("post_rst_2x9", p, 64'd18);
      check_eq("post_rst_lat", 64'(lat), 64'd18);

      for (int k = 0; k < 4; k++) begin
         for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 2; j++) begin
               logic [31:0] v;
               case ($urandom_range(0, 7))
                  0:       v = 32'd0;
                  1:       v = 32'hFFFF_FFFF;
                  2:       v = (k == 0) ? 32'h8000_0000 : 32'h0000_8000;
                  3:       v = 32'd1;
                  default: v = $urandom;
               endcase
               if (j == 0) a = v; else b = v;
            end
            s = 1'($urandom_range(0, 1));
            txn(k, a, b, s, $urandom_range(0, 3), p, lat);
            check_eq($sformatf("rand_prod_dut%0d", k), p, ref_prod(k, a, b, s));
            check_eq($sformatf("rand_lat_dut%0d", k), 64'(lat), 64'(lat_of(k)));
         end
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
